// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-side control blocks.
package fifo_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int BURST_MAX_DEFAULT = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last,
  output logic                 any,
  output logic [IDX_WIDTH-1:0] idx
);

  logic [IDX_WIDTH-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    // Scan farthest offset first so the nearest requester after 'last' overwrites.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_WIDTH'((int'(last) + k) % NUM_REQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = BURST_MAX_DEFAULT,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [IDX_WIDTH-1:0]          grant_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(BURST_MAX) + 1;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     beat_cnt, beat_cnt_nxt;
  logic [IDX_WIDTH-1:0] last_grant, last_grant_nxt, grant_nxt, pick_idx;
  logic                 pick_any, load_ok, accept, transfer, cur_valid, cur_last, burst_end;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_pick (
    .req (req_valid),
    .last(last_grant),
    .any (pick_any),
    .idx (pick_idx)
  );

  // The slot can take a new beat when empty or when its current beat leaves this edge.
  assign load_ok   = ~fifo_wr_en | ~fifo_full;
  assign accept    = fifo_wr_en & ~fifo_full;
  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign cur_data  = data_arr[grant_id];
  assign transfer  = (state == ST_BURST) & cur_valid & load_ok;
  assign burst_end = cur_last | (beat_cnt == CNT_W'(BURST_MAX - 1));
  assign busy      = (state == ST_BURST) | fifo_wr_en;

  always_comb begin
    req_ready = '0;
    if (state == ST_BURST && load_ok) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    beat_cnt_nxt   = beat_cnt;
    last_grant_nxt = last_grant;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
          state_nxt    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (transfer) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (burst_end) begin
            state_nxt      = ST_IDLE;
            last_grant_nxt = grant_id;
          end
        end else if (!cur_valid) begin
          // Requester abandoned its burst; a stall on full keeps the grant instead.
          state_nxt      = ST_IDLE;
          last_grant_nxt = grant_id;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
    end else if (transfer) begin
      fifo_wr_en   <= 1'b1;
      fifo_data_in <= cur_data;
    end else if (accept) begin
      fifo_wr_en   <= 1'b0;
    end
  end

endmodule
